// File: rtl/bram_wb_ctrl.sv
// Wishbone-classic slave in front of a single-port 32-bit BRAM without byte enables.
// Reads wait out a fixed BRAM latency; partial-word writes are done as read-modify-write.
module bram_wb_ctrl #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned LATENCY   = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_8000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_a,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_do,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] WR     = 3'd3;
    localparam logic [2:0] ACK    = 3'd4;

    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
    logic [3:0]        wsel, wsel_d;
    logic [31:0]       wdat, wdat_d;
    logic [31:0]       merge;
    logic [31:0]       dat_d, di_d;
    logic [ADDR_W-1:0] a_d;
    logic              req, hit;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign hit     = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign cnt_inc = CNT_W'(cnt + 1'b1);

    // Selected lanes come from the bus, the rest from the word just read back.
    always_comb begin
        merge = bram_do;
        for (int i = 0; i < 4; i++) begin
            if (wsel[i]) merge[8*i +: 8] = wdat[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wsel_d  = wsel;
        wdat_d  = wdat;
        dat_d   = wbs_dat_o;
        di_d    = bram_di;
        a_d     = bram_a;
        case (state)
            IDLE: begin
                if (req && hit) begin
                    a_d    = wbs_adr_i[ADDR_W+1:2];
                    di_d   = wbs_dat_i;
                    wsel_d = wbs_sel_i;
                    wdat_d = wbs_dat_i;
                    cnt_d  = '0;
                    if (!wbs_we_i)               state_d = RD;
                    else if (wbs_sel_i == 4'hF)  state_d = WR;
                    else if (wbs_sel_i == 4'h0)  state_d = ACK;
                    else                         state_d = RMW_RD;
                end
            end
            RD, RMW_RD: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_W'(LATENCY)) begin
                    cnt_d = '0;
                    if (state == RD) begin
                        dat_d   = bram_do;
                        state_d = ACK;
                    end else begin
                        di_d    = merge;
                        state_d = WR;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            // The write itself happens this cycle regardless; only the ack depends on the master.
            WR: begin
                cnt_d   = '0;
                state_d = req ? ACK : IDLE;
            end
            ACK: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wsel      <= '0;
            wdat      <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_a    <= '0;
            bram_di   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wsel      <= wsel_d;
            wdat      <= wdat_d;
            wbs_ack_o <= (state_d == ACK);
            wbs_dat_o <= dat_d;
            bram_en   <= (state_d == RD) || (state_d == RMW_RD) || (state_d == WR);
            bram_we   <= (state_d == WR);
            bram_a    <= a_d;
            bram_di   <= di_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_bram_wb_ctrl.sv
// Directed bench for bram_wb_ctrl: a LATENCY=10 instance and a LATENCY=1 instance,
// each with a behavioural BRAM, sharing one bus driver selected by use2.
module tb_bram_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we, use2;
    logic [3:0]  sel;
    logic [31:0] adr, dat;

    logic        ack1, en1, we1, busy1, ack2, en2, we2, busy2;
    logic [31:0] dato1, di1, do1, dato2, di2, do2;
    logic [12:0] a1, a2;
    logic [31:0] mem1 [8192];
    logic [31:0] mem2 [8192];

    logic        s_ack, s_en, s_we, s_busy;
    logic [31:0] s_dato, s_di;
    logic [12:0] s_a;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_wb_ctrl #(.LATENCY(10)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc & ~use2), .wbs_stb_i(stb & ~use2), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack1), .wbs_dat_o(dato1),
        .bram_en(en1), .bram_we(we1), .bram_a(a1), .bram_di(di1), .bram_do(do1),
        .busy(busy1)
    );

    bram_wb_ctrl #(.LATENCY(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc & use2), .wbs_stb_i(stb & use2), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack2), .wbs_dat_o(dato2),
        .bram_en(en2), .bram_we(we2), .bram_a(a2), .bram_di(di2), .bram_do(do2),
        .busy(busy2)
    );

    // Asynchronous-read BRAM models
    assign do1 = mem1[a1];
    assign do2 = mem2[a2];
    always @(posedge clk) begin
        if (en1 && we1) mem1[a1] <= di1;
        if (en2 && we2) mem2[a2] <= di2;
    end

    assign s_ack  = use2 ? ack2  : ack1;
    assign s_en   = use2 ? en2   : en1;
    assign s_we   = use2 ? we2   : we1;
    assign s_busy = use2 ? busy2 : busy1;
    assign s_dato = use2 ? dato2 : dato1;
    assign s_di   = use2 ? di2   : di1;
    assign s_a    = use2 ? a2    : a1;

    typedef struct {
        bit          d2;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          ack;   // expected ack cycle (accept = 0)
        logic [31:0] rd;    // expected wbs_dat_o at ack
        int          wr;    // expected BRAM write cycle, -1 = none
        logic [31:0] di;    // expected bram_di on the write cycle
        int          en;    // expected number of bram_en cycles
        logic [12:0] a;     // expected bram_a while enabled
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit d2, bit w, logic [3:0] s, logic [31:0] ad, logic [31:0] dt,
                                int ak, logic [31:0] rd, int wr, logic [31:0] di, int en,
                                logic [12:0] a);
        vec_t v;
        v.d2 = d2; v.we = w; v.sel = s; v.adr = ad; v.dat = dt; v.ack = ak;
        v.rd = rd; v.wr = wr; v.di = di; v.en = en; v.a = a;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transaction; inputs change on negedges, outputs are sampled on negedges.
    task automatic run(input vec_t t, output int ack_k, output logic [31:0] rd,
                       output int wr_k, output logic [31:0] wr_di, output int en_n,
                       output bit a_ok);
        int k;
        ack_k = -1; rd = 'x; wr_k = -1; wr_di = 'x; en_n = 0; a_ok = 1'b1;
        @(negedge clk);
        use2 = t.d2; cyc = 1'b1; stb = 1'b1; we = t.we; sel = t.sel; adr = t.adr; dat = t.dat;
        k = 0;
        while (ack_k < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (s_en) begin
                en_n++;
                if (s_a !== t.a) a_ok = 1'b0;
                if (s_we) begin
                    wr_k  = k;
                    wr_di = s_di;
                end
            end
            if (s_ack === 1'b1) begin
                ack_k = k;
                rd    = s_dato;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic run_check(input vec_t t, input string tag);
        int ak, wk, en;
        logic [31:0] rd, di;
        bit aok;
        run(t, ak, rd, wk, di, en, aok);
        chk({tag, " ack_cycle"}, 32'(ak), 32'(t.ack));
        chk({tag, " dat_o"}, rd, t.rd);
        chk({tag, " wr_cycle"}, 32'(wk), 32'(t.wr));
        chk({tag, " en_cycles"}, 32'(en), 32'(t.en));
        if (t.wr >= 0) chk({tag, " di"}, di, t.di);
        if (t.en > 0)  chk({tag, " addr_stable"}, 32'(aok), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; use2 = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0;
        sel = 4'hF; adr = 32'h3800_0010; dat = '0;

        // Vectors for the LATENCY=10 instance
        vecs.push_back(mk(0, 1, 4'hF, 32'h3800_0010, 32'hDEADBEEF,  2, 32'h0,        1, 32'hDEADBEEF,  1, 13'h4));
        vecs.push_back(mk(0, 0, 4'hF, 32'h3800_0010, 32'h0,        11, 32'hDEADBEEF, -1, 32'h0,       10, 13'h4));
        vecs.push_back(mk(0, 1, 4'hF, 32'h3800_0020, 32'h11223344,  2, 32'hDEADBEEF,  1, 32'h11223344, 1, 13'h8));
        vecs.push_back(mk(0, 1, 4'h5, 32'h3800_0020, 32'hAABBCCDD, 12, 32'hDEADBEEF, 11, 32'h11BB33DD, 11, 13'h8));
        vecs.push_back(mk(0, 0, 4'hF, 32'h3800_0020, 32'h0,        11, 32'h11BB33DD, -1, 32'h0,       10, 13'h8));
        vecs.push_back(mk(0, 1, 4'h0, 32'h3800_0020, 32'hFFFFFFFF,  1, 32'h11BB33DD, -1, 32'h0,        0, 13'h8));
        vecs.push_back(mk(0, 0, 4'hF, 32'h3800_0020, 32'h0,        11, 32'h11BB33DD, -1, 32'h0,       10, 13'h8));
        vecs.push_back(mk(0, 1, 4'hF, 32'h3800_7FFC, 32'hCAFEF00D,  2, 32'h11BB33DD,  1, 32'hCAFEF00D, 1, 13'h1FFF));
        vecs.push_back(mk(0, 0, 4'hF, 32'h3800_7FFC, 32'h0,        11, 32'hCAFEF00D, -1, 32'h0,       10, 13'h1FFF));
        vecs.push_back(mk(0, 1, 4'h8, 32'h3800_0010, 32'h55667788, 12, 32'hCAFEF00D, 11, 32'h55ADBEEF, 11, 13'h4));
        vecs.push_back(mk(0, 0, 4'h1, 32'h3800_0010, 32'h0,        11, 32'h55ADBEEF, -1, 32'h0,       10, 13'h4));
        // Vectors for the LATENCY=1 instance
        vecs.push_back(mk(1, 1, 4'hF, 32'h3800_0100, 32'h01020304,  2, 32'h0,         1, 32'h01020304, 1, 13'h40));
        vecs.push_back(mk(1, 0, 4'hF, 32'h3800_0100, 32'h0,         2, 32'h01020304, -1, 32'h0,        1, 13'h40));
        vecs.push_back(mk(1, 1, 4'h3, 32'h3800_0100, 32'hAAAABBBB,  3, 32'h01020304,  2, 32'h0102BBBB, 2, 13'h40));
        vecs.push_back(mk(1, 0, 4'hF, 32'h3800_0100, 32'h0,         2, 32'h0102BBBB, -1, 32'h0,        1, 13'h40));

        // T1: reset held with an active, decoded request
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst ack", 32'(ack1), 32'd0);
            chk("rst en", 32'(en1), 32'd0);
            chk("rst busy", 32'(busy1), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("rst dat_o", dato1, 32'h0);
        chk("rst bram_a", 32'(a1), 32'h0);
        chk("rst bram_di", di1, 32'h0);
        chk("rst bram_we", 32'(we1), 32'd0);
        chk("rst busy2", 32'(busy2), 32'd0);

        // T4: requests just outside the decode window are ignored
        for (int m = 0; m < 2; m++) begin
            bit seen_ack, seen_en, seen_busy;
            seen_ack = 0; seen_en = 0; seen_busy = 0;
            @(negedge clk);
            use2 = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
            adr = (m == 0) ? 32'h3000_0000 : 32'h3800_8000;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (ack1)  seen_ack  = 1;
                if (en1)   seen_en   = 1;
                if (busy1) seen_busy = 1;
            end
            cyc = 1'b0; stb = 1'b0;
            chk("miss ack", 32'(seen_ack), 32'd0);
            chk("miss en", 32'(seen_en), 32'd0);
            chk("miss busy", 32'(seen_busy), 32'd0);
        end

        foreach (vecs[i]) run_check(vecs[i], $sformatf("vec%0d", i));

        // T5: read aborted by dropping stb/cyc in cycle 4
        begin
            bit seen_ack;
            seen_ack = 0;
            @(negedge clk);
            use2 = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0020;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                if (ack1) seen_ack = 1;
                if (k == 4) begin
                    chk("abort rd busy c4", 32'(busy1), 32'd1);
                    cyc = 1'b0; stb = 1'b0;
                end
                if (k == 5) begin
                    chk("abort rd busy c5", 32'(busy1), 32'd0);
                    chk("abort rd en c5", 32'(en1), 32'd0);
                end
            end
            chk("abort rd no ack", 32'(seen_ack), 32'd0);
            run_check(mk(0, 0, 4'hF, 32'h3800_0020, 32'h0, 11, 32'h11BB33DD, -1, 32'h0, 10, 13'h8),
                      "after_abort");
        end

        // Abort during the write cycle: data lands, ack is suppressed
        begin
            bit seen_ack;
            seen_ack = 0;
            @(negedge clk);
            use2 = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
            adr = 32'h3800_0030; dat = 32'h0BADCAFE;
            @(negedge clk);
            chk("abort wr en_we", 32'({en1, we1}), 32'h3);
            cyc = 1'b0; stb = 1'b0;
            @(negedge clk);
            chk("abort wr busy", 32'(busy1), 32'd0);
            for (int k = 0; k < 4; k++) begin
                if (ack1) seen_ack = 1;
                @(negedge clk);
            end
            chk("abort wr no ack", 32'(seen_ack), 32'd0);
            run_check(mk(0, 0, 4'hF, 32'h3800_0030, 32'h0, 11, 32'h0BADCAFE, -1, 32'h0, 10, 13'hC),
                      "after_wr_abort");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
